// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory-side signals of the shared memory port
interface mem_port_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int AW    = 16,
  parameter int DW    = 16
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_we;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_wdata;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    rsp_valid;
  logic [DW-1:0]       rsp_data;
  logic [AW-1:0]       mem_raddr;
  logic [DW-1:0]       mem_rdata;
  logic [AW-1:0]       mem_waddr;
  logic [DW-1:0]       mem_wdata;
  logic                mem_wen;
  logic                busy;
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_data, mem_raddr, mem_waddr, mem_wdata, mem_wen, busy
  );
  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, mem_raddr, mem_waddr, mem_wdata, mem_wen, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory read/write port, one transaction in flight
module mem_port_arbiter #(
  parameter int N_REQ  = 2,
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 2
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(RD_LAT + 1);
  typedef enum logic [1:0] {IDLE, WR, RD, RSP} state_t;
  state_t          r_state, w_next;
  logic [PW-1:0]   r_ptr, r_win, w_win, w_idx;
  logic            w_found, w_grant, w_we;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_raddr, r_waddr;
  logic [DW-1:0]   r_wdata, r_rsp_data;
  logic            r_wen;
  assign w_grant = (r_state == IDLE) && w_found;
  assign w_we    = bus.req_we[w_win];
  assign bus.req_ready = w_grant ? N_REQ'(1) << w_win : '0;
  assign bus.rsp_valid = (r_state == WR || r_state == RSP) ? N_REQ'(1) << r_win : '0;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.mem_raddr = r_raddr;
  assign bus.mem_waddr = r_waddr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_wen   = r_wen;
  assign bus.busy      = r_state != IDLE;
  // pick the first pending requester at or after r_ptr, wrapping modulo N_REQ
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = PW'((int'(r_ptr) + k) % N_REQ);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  // next state: stores ack right after the write, loads wait out the read latency
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE)    w_next = w_grant ? (w_we ? WR : RD) : IDLE;
    else if (r_state == RD) w_next = (r_cnt == '0) ? RSP : RD;
    else                    w_next = IDLE;
  end
  // latch the granted transaction, drive the memory port and capture read data
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ptr      <= '0;
      r_win      <= '0;
      r_cnt      <= '0;
      r_raddr    <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_wen      <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      r_wen <= w_grant && w_we;
      if (w_grant) begin
        r_win <= w_win;
        r_ptr <= (w_win == PW'(N_REQ - 1)) ? '0 : w_win + 1'b1;
        r_cnt <= CW'(RD_LAT);
        if (w_we) begin
          r_waddr <= bus.req_addr[w_win*AW +: AW];
          r_wdata <= bus.req_wdata[w_win*DW +: DW];
        end else
          r_raddr <= bus.req_addr[w_win*AW +: AW];
      end else if (r_state == RD) begin
        if (r_cnt == '0) r_rsp_data <= bus.mem_rdata;
        else             r_cnt <= r_cnt - 1'b1;
      end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grants, latencies, ordering and async reset
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  int n_tests = 0;
  int n_fail  = 0;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.N_REQ(2), .AW(16), .DW(16)) b2 ();
  mem_port_arbiter_if #(.N_REQ(3), .AW(16), .DW(16)) b3 ();
  mem_port_arbiter #(.N_REQ(2), .AW(16), .DW(16), .RD_LAT(2)) d2 (.clk(clk), .rst(rst), .bus(b2.slave));
  mem_port_arbiter #(.N_REQ(3), .AW(16), .DW(16), .RD_LAT(2)) d3 (.clk(clk), .rst(rst), .bus(b3.slave));
  logic [15:0] mem [0:255];
  logic [15:0] p1, p2;
  assign b2.mem_rdata = p2;
  assign b3.mem_rdata = '0;
  // memory with a two-cycle read pipeline behind d2
  always @(posedge clk) begin
    if (rst) mem[8'h40] <= 16'hBEEF;
    else if (b2.mem_wen) mem[b2.mem_waddr[7:0]] <= b2.mem_wdata;
    p1 <= mem[b2.mem_raddr[7:0]];
    p2 <= p1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b0;
    b2.req_valid = '0; b2.req_we = '0; b2.req_addr = '0; b2.req_wdata = '0;
    b3.req_valid = '0; b3.req_we = '0; b3.req_addr = '0; b3.req_wdata = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_ready", b2.req_ready, 0);
    chk("rst_rsp", b2.rsp_valid, 0);
    chk("rst_data", b2.rsp_data, 0);
    chk("rst_raddr", b2.mem_raddr, 0);
    chk("rst_waddr", b2.mem_waddr, 0);
    chk("rst_wdata", b2.mem_wdata, 0);
    chk("rst_wen", b2.mem_wen, 0);
    chk("rst_busy", b2.busy, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); b2.req_valid = 2'b01; b2.req_we = 2'b00; b2.req_addr = 32'h0010_0040;
    #1 chk("a_grant", b2.req_ready, 2'b01);
    @(negedge clk); b2.req_valid = 2'b00;
    #1 chk("a_raddr", b2.mem_raddr, 16'h0040);
    chk("a_busy", b2.busy, 1);
    chk("a_noready", b2.req_ready, 0);
    @(negedge clk); #1 chk("a_rsp_t2", b2.rsp_valid, 0);
    @(negedge clk); #1 chk("a_rsp_t3", b2.rsp_valid, 0);
    @(negedge clk); #1 chk("a_rsp", b2.rsp_valid, 2'b01);
    chk("a_data", b2.rsp_data, 16'hBEEF);
    @(negedge clk); #1 chk("a_idle", b2.busy, 0);
    chk("a_rsp_off", b2.rsp_valid, 0);
    chk("a_hold", b2.rsp_data, 16'hBEEF);
    @(negedge clk); b2.req_valid = 2'b11; b2.req_we = 2'b10; b2.req_addr = 32'h0010_0010; b2.req_wdata = 32'h1234_0000;
    #1 chk("b_grant_st", b2.req_ready, 2'b10);
    @(negedge clk); b2.req_valid = 2'b01; b2.req_we = 2'b00;
    #1 chk("b_wen", b2.mem_wen, 1);
    chk("b_waddr", b2.mem_waddr, 16'h0010);
    chk("b_wdata", b2.mem_wdata, 16'h1234);
    chk("b_ack", b2.rsp_valid, 2'b10);
    chk("b_ready_wr", b2.req_ready, 0);
    @(negedge clk); #1 chk("b_grant_ld", b2.req_ready, 2'b01);
    chk("b_wen_off", b2.mem_wen, 0);
    @(negedge clk); b2.req_valid = 2'b00;
    #1 chk("b_raddr", b2.mem_raddr, 16'h0010);
    repeat (2) @(negedge clk);
    @(negedge clk); #1 chk("b_rsp", b2.rsp_valid, 2'b01);
    chk("b_data", b2.rsp_data, 16'h1234);
    @(negedge clk); b2.req_valid = 2'b10; b2.req_we = 2'b00; b2.req_addr = 32'h0040_0000;
    #1 chk("c_grant", b2.req_ready, 2'b10);
    @(negedge clk); b2.req_valid = 2'b00;
    #1 chk("c_raddr", b2.mem_raddr, 16'h0040);
    chk("c_busy", b2.busy, 1);
    #1 rst = 1'b1;
    #1 chk("c_rst_busy", b2.busy, 0);
    chk("c_rst_raddr", b2.mem_raddr, 0);
    chk("c_rst_data", b2.rsp_data, 0);
    chk("c_rst_rsp", b2.rsp_valid, 0);
    chk("c_rst_ready", b2.req_ready, 0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1 chk("c_no_rsp", b2.rsp_valid, 0);
    end
    @(negedge clk); b2.req_valid = 2'b11; b2.req_we = 2'b00; b2.req_addr = 32'h0010_0040;
    for (int i = 0; i < 4; i++) begin
      #1 chk("d_grant", b2.req_ready, (i % 2) ? 2'b10 : 2'b01);
      repeat (4) @(negedge clk);
      #1 chk("d_rsp", b2.rsp_valid, (i % 2) ? 2'b10 : 2'b01);
      chk("d_data", b2.rsp_data, (i % 2) ? 16'h1234 : 16'hBEEF);
      @(negedge clk);
    end
    b2.req_valid = 2'b00;
    @(negedge clk); b2.req_valid = 2'b10; b2.req_we = 2'b10; b2.req_addr = 32'h0020_0055; b2.req_wdata = 32'hA5A5_0000;
    #1 chk("e_grant", b2.req_ready, 2'b10);
    @(negedge clk); b2.req_valid = 2'b01; b2.req_we = 2'b00;
    #1 chk("e_wen", b2.mem_wen, 1);
    chk("e_wdata", b2.mem_wdata, 16'hA5A5);
    chk("e_ready_busy", b2.req_ready, 0);
    @(negedge clk); b2.req_valid = 2'b00;
    #1 chk("e_wen_off", b2.mem_wen, 0);
    chk("e_ready_drop", b2.req_ready, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1 chk("e_busy", b2.busy, 0);
      chk("e_raddr", b2.mem_raddr, 16'h0010);
    end
    @(negedge clk); b3.req_valid = 3'b010; b3.req_we = 3'b111;
    #1 chk("f_first", b3.req_ready, 3'b010);
    @(negedge clk); b3.req_valid = 3'b101;
    #1 chk("f_wr_ready", b3.req_ready, 0);
    chk("f_ack", b3.rsp_valid, 3'b010);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1 chk("f_grant", b3.req_ready, (i == 1) ? 3'b001 : 3'b100);
      @(negedge clk); #1 chk("f_wr", b3.req_ready, 0);
    end
    @(negedge clk); b3.req_valid = 3'b000;
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
